// File: rtl/mips_abb_pkg.sv
// Shared types and constants for the MIPS pipeline blocks.
package mips_abb_pkg;

  typedef logic [31:0] reg_word;
  typedef logic [4:0]  reg_addr;

  localparam reg_addr REG_ZERO = 5'd0;
  localparam reg_word ZERO     = 32'h0000_0000;
  localparam logic    RESET    = 1'b1;

  // Load formatting selector carried from MEM into WB.
  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } load_op;

  // MEM/WB pipeline register.
  typedef struct packed {
    logic       valid;
    logic       wreg;
    reg_addr    wa;
    reg_word    result;
    load_op     memop;
    logic [1:0] addr_lo;
  } wb_reg_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Little-endian load extraction and alignment check (purely combinational).
module load_align
  import mips_abb_pkg::*;
(
  input  load_op     memop_i,
  input  logic [1:0] addr_lo_i,
  input  reg_word    rdata_i,
  input  reg_word    result_i,
  output reg_word    data_o,
  output logic       misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend according to the load type.
  always_comb begin
    byte_sel   = rdata_i[8*addr_lo_i +: 8];
    half_sel   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o     = result_i;
    misalign_o = 1'b0;
    unique case (memop_i)
      LD_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: data_o = {24'h000000, byte_sel};
      LD_LH: begin
        data_o     = {{16{half_sel[15]}}, half_sel};
        misalign_o = addr_lo_i[0];
      end
      LD_LHU: begin
        data_o     = {16'h0000, half_sel};
        misalign_o = addr_lo_i[0];
      end
      LD_LW: begin
        data_o     = rdata_i;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: data_o = result_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load formatting, RF write port, retire counter.
module wb_stage
  import mips_abb_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst_n,
  input  logic             mem_valid,
  input  logic             mem_wreg,
  input  reg_addr          mem_wa,
  input  reg_word          mem_result,
  input  load_op           mem_memop,
  input  logic [1:0]       mem_addr_lo,
  input  reg_word          dm_rdata,
  input  logic             wb_stall,
  input  logic             wb_flush,
  output logic             rf_write_en,
  output reg_addr          rf_write_add,
  output reg_word          rf_write_data,
  output logic             wb_misalign,
  output logic [CNT_W-1:0] wb_retire_cnt
);

  wb_reg_t          wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q;
  reg_word          fmt_data;
  logic             fmt_misalign;
  logic             misalign;
  logic             retire;

  load_align u_load_align (
    .memop_i    (wb_q.memop),
    .addr_lo_i  (wb_q.addr_lo),
    .rdata_i    (dm_rdata),
    .result_i   (wb_q.result),
    .data_o     (fmt_data),
    .misalign_o (fmt_misalign)
  );

  // Next WB contents: stall holds, flush/invalid loads a bubble, else capture MEM.
  always_comb begin
    wb_d = wb_q;
    if (!wb_stall) begin
      if (wb_flush || !mem_valid) begin
        wb_d = '0;
      end else begin
        wb_d.valid   = 1'b1;
        wb_d.wreg    = mem_wreg;
        wb_d.wa      = mem_wa;
        wb_d.result  = mem_result;
        wb_d.memop   = mem_memop;
        wb_d.addr_lo = mem_addr_lo;
      end
    end
  end

  // Pipeline register and retire counter, asynchronously cleared.
  always_ff @(posedge cpu_clk or posedge cpu_rst_n) begin
    if (cpu_rst_n == RESET) begin
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q <= wb_d;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Write-port and status outputs derived from WB contents only.
  always_comb begin
    misalign      = wb_q.valid & fmt_misalign;
    retire        = wb_q.valid & ~wb_stall & ~misalign;
    rf_write_en   = retire & wb_q.wreg & (wb_q.wa != REG_ZERO);
    rf_write_add  = wb_q.wa;
    rf_write_data = fmt_data;
    wb_misalign   = misalign;
    wb_retire_cnt = cnt_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;
  import mips_abb_pkg::*;

  logic       cpu_clk = 1'b0;
  logic       cpu_rst_n;
  logic       mem_valid, mem_wreg;
  reg_addr    mem_wa;
  reg_word    mem_result;
  load_op     mem_memop;
  logic [1:0] mem_addr_lo;
  reg_word    dm_rdata;
  logic       wb_stall, wb_flush;

  logic        rf_write_en, rf_write_en_s;
  reg_addr     rf_write_add, rf_write_add_s;
  reg_word     rf_write_data, rf_write_data_s;
  logic        wb_misalign, wb_misalign_s;
  logic [31:0] cnt;
  logic [2:0]  cnt_s;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 cpu_clk = ~cpu_clk;

  wb_stage dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .mem_valid(mem_valid),
    .mem_wreg(mem_wreg), .mem_wa(mem_wa), .mem_result(mem_result),
    .mem_memop(mem_memop), .mem_addr_lo(mem_addr_lo), .dm_rdata(dm_rdata),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .rf_write_en(rf_write_en),
    .rf_write_add(rf_write_add), .rf_write_data(rf_write_data),
    .wb_misalign(wb_misalign), .wb_retire_cnt(cnt)
  );

  // Narrow-counter copy on the same stimulus, used to observe wraparound.
  wb_stage #(.CNT_W(3)) dut_w (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .mem_valid(mem_valid),
    .mem_wreg(mem_wreg), .mem_wa(mem_wa), .mem_result(mem_result),
    .mem_memop(mem_memop), .mem_addr_lo(mem_addr_lo), .dm_rdata(dm_rdata),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .rf_write_en(rf_write_en_s),
    .rf_write_add(rf_write_add_s), .rf_write_data(rf_write_data_s),
    .wb_misalign(wb_misalign_s), .wb_retire_cnt(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // Present one MEM instruction, clock it into WB, then leave bubbles behind it.
  task automatic issue(input logic wreg, input reg_addr wa, input reg_word res,
                       input load_op op, input logic [1:0] lo);
    mem_valid   = 1'b1;
    mem_wreg    = wreg;
    mem_wa      = wa;
    mem_result  = res;
    mem_memop   = op;
    mem_addr_lo = lo;
    step();
    mem_valid = 1'b0;
  endtask

  typedef struct {
    load_op     op;
    logic [1:0] lo;
    reg_word    exp;
  } load_vec_t;

  load_vec_t loads [5];

  initial begin
    loads[0] = '{LD_LB,  2'd3, 32'hFFFF_FF80};
    loads[1] = '{LD_LBU, 2'd1, 32'h0000_007F};
    loads[2] = '{LD_LH,  2'd2, 32'hFFFF_80FF};
    loads[3] = '{LD_LHU, 2'd0, 32'h0000_7F01};
    loads[4] = '{LD_LW,  2'd0, 32'h80FF_7F01};

    cpu_rst_n = 1'b1;
    mem_valid = 1'b0; mem_wreg = 1'b0; mem_wa = '0; mem_result = '0;
    mem_memop = LD_NONE; mem_addr_lo = '0;
    dm_rdata = 32'h80FF_7F01;
    wb_stall = 1'b0; wb_flush = 1'b0;
    step(); step();
    cpu_rst_n = 1'b0;

    check("rst_en",   {31'd0, rf_write_en}, 32'd0);
    check("rst_add",  {27'd0, rf_write_add}, 32'd0);
    check("rst_data", rf_write_data, 32'd0);
    check("rst_mis",  {31'd0, wb_misalign}, 32'd0);
    check("rst_cnt",  cnt, 32'd0);

    // ALU write
    issue(1'b1, 5'd5, 32'h1234_5678, LD_NONE, 2'd0);
    check("alu_en",   {31'd0, rf_write_en}, 32'd1);
    check("alu_add",  {27'd0, rf_write_add}, 32'd5);
    check("alu_data", rf_write_data, 32'h1234_5678);
    check("alu_cnt0", cnt, 32'd0);
    step();
    check("alu_cnt1", cnt, 32'd1);
    check("alu_bub",  {31'd0, rf_write_en}, 32'd0);

    // Load formatting
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, reg_addr'(i + 1), 32'hDEAD_BEEF, loads[i].op, loads[i].lo);
      check($sformatf("ld%0d_data", i), rf_write_data, loads[i].exp);
      check($sformatf("ld%0d_en", i), {31'd0, rf_write_en}, 32'd1);
      check($sformatf("ld%0d_mis", i), {31'd0, wb_misalign}, 32'd0);
      step();
      check($sformatf("ld%0d_cnt", i), cnt, 32'(i + 2));
    end

    // Misaligned loads: no write, no retire
    issue(1'b1, 5'd8, 32'h0, LD_LW, 2'd2);
    check("mlw_mis", {31'd0, wb_misalign}, 32'd1);
    check("mlw_en",  {31'd0, rf_write_en}, 32'd0);
    step();
    check("mlw_cnt", cnt, 32'd6);
    issue(1'b1, 5'd8, 32'h0, LD_LH, 2'd1);
    check("mlh_mis", {31'd0, wb_misalign}, 32'd1);
    check("mlh_en",  {31'd0, rf_write_en}, 32'd0);
    step();
    check("mlh_cnt", cnt, 32'd6);
    check("mlh_clr", {31'd0, wb_misalign}, 32'd0);

    // Stall for 3 cycles on a write to r7; a flushed MEM instruction is ignored meanwhile
    issue(1'b1, 5'd7, 32'hCAFE_0007, LD_NONE, 2'd0);
    wb_stall = 1'b1;
    mem_valid = 1'b1; mem_wa = 5'd9; wb_flush = 1'b1;
    #1;
    check("stl_en0", {31'd0, rf_write_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stl%0d_en", i), {31'd0, rf_write_en}, 32'd0);
      check($sformatf("stl%0d_add", i), {27'd0, rf_write_add}, 32'd7);
      check($sformatf("stl%0d_cnt", i), cnt, 32'd6);
    end
    wb_stall = 1'b0; wb_flush = 1'b0; mem_valid = 1'b0;
    #1;
    check("stl_pulse", {31'd0, rf_write_en}, 32'd1);
    check("stl_data",  rf_write_data, 32'hCAFE_0007);
    step();
    check("stl_cnt",   cnt, 32'd7);
    check("stl_once",  {31'd0, rf_write_en}, 32'd0);
    check("w_cnt7",    {29'd0, cnt_s}, 32'd7);

    // Flush with a valid MEM instruction
    mem_valid = 1'b1; mem_wreg = 1'b1; mem_wa = 5'd10; mem_memop = LD_NONE;
    wb_flush = 1'b1;
    step();
    wb_flush = 1'b0; mem_valid = 1'b0;
    check("fl_en", {31'd0, rf_write_en}, 32'd0);
    step();
    check("fl_cnt", cnt, 32'd7);

    // Write to $0: suppressed but retired; narrow counter wraps 7 -> 0
    issue(1'b1, 5'd0, 32'h5555_5555, LD_NONE, 2'd0);
    check("r0_en", {31'd0, rf_write_en}, 32'd0);
    step();
    check("r0_cnt", cnt, 32'd8);
    check("w_wrap", {29'd0, cnt_s}, 32'd0);

    // Asynchronous reset while a load is in WB
    issue(1'b1, 5'd12, 32'h0, LD_LW, 2'd0);
    check("pre_en",   {31'd0, rf_write_en}, 32'd1);
    check("pre_data", rf_write_data, 32'h80FF_7F01);
    #2;
    cpu_rst_n = 1'b1;
    #1;
    check("ar_en",   {31'd0, rf_write_en}, 32'd0);
    check("ar_add",  {27'd0, rf_write_add}, 32'd0);
    check("ar_data", rf_write_data, 32'd0);
    check("ar_mis",  {31'd0, wb_misalign}, 32'd0);
    check("ar_cnt",  cnt, 32'd0);
    step();
    cpu_rst_n = 1'b0;

    // One retire after reset
    issue(1'b1, 5'd3, 32'h0000_00AA, LD_NONE, 2'd0);
    step();
    check("post_cnt", cnt, 32'd1);
    check("post_w",   {29'd0, cnt_s}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage MIPS pipeline. It holds the MEM/WB pipeline register, extends and aligns load data from the synchronous data memory, and drives the register file write port. Because the register file bypasses same-cycle writes, ID sees the result in the cycle it is written. It also keeps a retired-instruction counter for the code monitor.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- cpu_clk  in  1  pipeline clock.
- cpu_rst_n  in  1  reset, asynchronous, active-high. Asserted when equal to RESET, which is 1'b1 for this block; the _n suffix is kept only for name consistency.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_wreg  in  1  instruction writes a GPR.
- mem_wa  in  reg_addr  destination register.
- mem_result  in  reg_word  ALU/link result.
- mem_memop  in  load_op  one of LD_NONE, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW.
- mem_addr_lo  in  2  effective address bits [1:0].
- dm_rdata  in  reg_word  data-memory read word. Valid in the cycle its load is in WB.
- wb_stall  in  1  hold WB contents.
- wb_flush  in  1  cancel the instruction entering from MEM.
- rf_write_en  out  1  register file write enable.
- rf_write_add  out  reg_addr  register file write address.
- rf_write_data  out  reg_word  register file write data.
- wb_misalign  out  1  misaligned load currently in WB.
- wb_retire_cnt  out  CNT_W  count of retired instructions.

## Operation
- WB register fields: valid, wreg, wa, result, memop, addr_lo.
- Register update, evaluated at each cpu_clk edge, in priority order:
  1. Reset asserted: all fields cleared; valid=0.
  2. wb_stall=1: hold all fields.
  3. wb_flush=1 or mem_valid=0: load a bubble (valid=0).
  4. Otherwise: capture the mem_* inputs.
- Load formatting is little-endian; byte k is dm_rdata[8k+7:8k].
  - LB/LBU: select byte addr_lo; LB sign-extends, LBU zero-extends.
  - LH/LHU: select half addr_lo[1]; LH sign-extends, LHU zero-extends.
  - LW: the whole word.
  - LD_NONE: write data is result.
- misalign = valid & ((LH/LHU & addr_lo[0]) | (LW & addr_lo≠0)).
- retire = valid & ~wb_stall & ~misalign.
- rf_write_en = retire & wreg & (wa ≠ REG_ZERO).
- rf_write_add = wa; rf_write_data = the formatted value. Both are driven regardless of rf_write_en.
- wb_misalign = misalign. It does not depend on the stall state.
- wb_retire_cnt increments by 1 on each edge where retire=1. It wraps from all-ones to 0.

## Timing
- Latency: an instruction presented on mem_* at edge N drives rf_write_en in cycle N..N+1, and the register file commits it at edge N+1.
- Under stall: rf_write_en stays 0 and the counter does not advance. The write and count happen exactly once, in the first unstalled cycle.
- Stall and flush together: stall wins. The WB contents are held, and the MEM instruction is left for upstream to handle.
- Reset values: rf_write_en=0, rf_write_add=0, rf_write_data=ZERO, wb_misalign=0, wb_retire_cnt=0.
- Reset asserted mid-stall or mid-load takes effect immediately and asynchronously. Outputs reach reset values without waiting for a clock edge.
- Writes to $0 are suppressed here, but the instruction still counts as retired.
- Output paths from the WB register and dm_rdata are combinational only; there is no path from mem_* to any output.

## Structure
- Add to mips_abb_pkg:
  - the load_op enum (3-bit, LD_NONE=0);
  - a wb_reg_t struct for the pipeline register.
- Reuse the package's existing reg_word, reg_addr, REG_ZERO, ZERO and RESET.
- Sub-module load_align: purely combinational (memop, addr_lo, dm_rdata → data, misalign). Instantiated once, and unit-testable on its own.

## Test plan
- ALU write: mem_wreg=1, mem_wa=5, mem_result=0x1234_5678, LD_NONE. Next cycle: rf_write_en=1, add=5, data=0x1234_5678, and the counter goes 0→1.
- Loads with dm_rdata=0x80FF_7F01:
  - LB, addr_lo=3 → 0xFFFF_FF80.
  - LBU, addr_lo=1 → 0x0000_007F.
  - LH, addr_lo=2 → 0xFFFF_80FF.
  - LHU, addr_lo=0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- Misalign: LW with addr_lo=2 → wb_misalign=1, rf_write_en=0, counter unchanged. The same applies to LH with addr_lo=1.
- Stall: hold wb_stall=1 for 3 cycles on a write to r7. rf_write_en=0 throughout; then exactly one write pulse and exactly one counter increment.
- Flush and $0:
  - wb_flush with a valid MEM instruction → bubble; no write, no count.
  - A write to r0 → rf_write_en=0, counter increments.
- Reset: assert cpu_rst_n between clock edges while a load is in WB. All outputs go to 0 before the next edge. The counter preset near all-ones then wraps to 0 after the expected number of retires.
